// File: rtl/cam_table_lookup.sv
// cam_table_lookup: sweeps a DEPTH-entry CAM SRAM for a key; reports hit and lowest matching index.
// Optional macro CAM_LOOKUP_EARLY_EXIT_EN: respond on the first match instead of sweeping all entries.
module cam_table_lookup #(
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 48,
  parameter int READ_LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  ARST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_key,
  input  logic [DEPTH-1:0]      entry_valid,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rd,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [ADDR_WIDTH-1:0] rsp_index
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESP} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] key;
  logic [DEPTH-1:0] mask;
  logic [ADDR_WIDTH-1:0] tag_a [READ_LATENCY];
  logic [READ_LATENCY-1:0] tag_v;
  logic accept, issue, match, last_out, flush;
  // Reset gates req_ready so nothing is accepted while the engine is held in reset.
  assign req_ready = ARST_N && state == IDLE;
  assign rsp_valid = state == RESP;
  assign accept    = req_valid && req_ready;
  assign issue     = state == SCAN;
  assign match     = tag_v[READ_LATENCY-1] && rd == key && mask[tag_a[READ_LATENCY-1]];
  assign last_out  = tag_v[READ_LATENCY-1] && tag_a[READ_LATENCY-1] == LAST;
`ifdef CAM_LOOKUP_EARLY_EXIT_EN
  assign flush = match && !rsp_hit;
`else
  assign flush = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? SCAN : IDLE;
      SCAN:    state_nx = flush ? RESP : (raddr == LAST ? DRAIN : SCAN);
      DRAIN:   state_nx = (flush || last_out) ? RESP : DRAIN;
      default: state_nx = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state     <= IDLE;
      key       <= '0;
      mask      <= '0;
      raddr     <= '0;
      rsp_hit   <= 1'b0;
      rsp_index <= '0;
      tag_v     <= '0;
      for (int k = 0; k < READ_LATENCY; k++) tag_a[k] <= '0;
    end else begin
      state    <= state_nx;
      tag_a[0] <= raddr;
      tag_v[0] <= issue && !flush;
      for (int k = 1; k < READ_LATENCY; k++) begin
        tag_a[k] <= tag_a[k-1];
        tag_v[k] <= tag_v[k-1] && !flush;
      end
      if (accept) begin
        key       <= req_key;
        mask      <= entry_valid;
        rsp_hit   <= 1'b0;
        rsp_index <= '0;
        raddr     <= '0;
      end else begin
        if (issue && raddr != LAST && !flush) raddr <= raddr + ADDR_WIDTH'(1);
        // Only the first match is captured so the lowest index wins.
        if (match && !rsp_hit) begin
          rsp_hit   <= 1'b1;
          rsp_index <= tag_a[READ_LATENCY-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_cam_table_lookup.sv
// tb_cam_table_lookup: directed checks of cam_table_lookup against a 2-cycle SRAM model.
module tb_cam_table_lookup;
  logic        CLK = 1'b0;
  logic        ARST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [47:0] req_key = '0;
  logic [15:0] entry_valid = '0;
  logic [3:0]  raddr;
  logic [47:0] rd;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_hit;
  logic [3:0]  rsp_index;
  logic [47:0] mem [16];
  logic [47:0] p1;
  int compared = 0;
  int mismatched = 0;

  cam_table_lookup dut (
    .CLK(CLK), .ARST_N(ARST_N), .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .entry_valid(entry_valid), .raddr(raddr), .rd(rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_index(rsp_index)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    p1 <= mem[raddr];
    rd <= p1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input bit hit, input int idx);
`ifdef CAM_LOOKUP_EARLY_EXIT_EN
    return hit ? idx + 4 : 19;
`else
    return 19;
`endif
  endfunction

  task automatic lookup(input string tag, input logic [47:0] k, input logic [15:0] m,
                        input bit ehit, input logic [3:0] eidx, input int hold);
    int n;
    @(negedge CLK);
    check({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
    req_key = k; entry_valid = m; req_valid = 1'b1; rsp_ready = (hold == 0);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(exp_lat(ehit, int'(eidx))));
    check({tag, "_hit"}, 64'(rsp_hit), 64'(ehit));
    check({tag, "_index"}, 64'(rsp_index), 64'(ehit ? eidx : 4'd0));
    check({tag, "_ready_low"}, 64'(req_ready), 64'd0);
    for (int c = 0; c < hold; c++) begin
      @(posedge CLK); #1;
      check({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, "_hold_hit"}, 64'(rsp_hit), 64'(ehit));
      check({tag, "_hold_index"}, 64'(rsp_index), 64'(ehit ? eidx : 4'd0));
      check({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
    end
    if (hold != 0) begin
      @(negedge CLK);
      rsp_ready = 1'b1;
    end
    @(posedge CLK); #1;
    check({tag, "_post_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_post_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 16; i++) mem[i] = 48'hC0DE_0000_0000 + 48'(i);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_hit", 64'(rsp_hit), 64'd0);
    check("rst_rsp_index", 64'(rsp_index), 64'd0);
    check("rst_raddr", 64'(raddr), 64'd0);
    @(negedge CLK); ARST_N = 1'b1;
    @(posedge CLK); #1;
    check("rel_req_ready", 64'(req_ready), 64'd1);

    mem[5] = 48'h0011_2233_4455;
    lookup("hit5", 48'h0011_2233_4455, 16'hFFFF, 1'b1, 4'd5, 0);

    mem[3] = 48'hAABB_CCDD_EEFF; mem[12] = 48'hAABB_CCDD_EEFF;
    lookup("dup3_12", 48'hAABB_CCDD_EEFF, 16'hFFFF, 1'b1, 4'd3, 0);

    mem[7] = 48'h1234_5678_9ABC;
    lookup("masked7", 48'h1234_5678_9ABC, 16'hFF7F, 1'b0, 4'd0, 0);
    lookup("mask_zero", 48'h0011_2233_4455, 16'h0000, 1'b0, 4'd0, 0);

    mem[9] = 48'h9999_9999_9999;
    lookup("hold9", 48'h9999_9999_9999, 16'hFFFF, 1'b1, 4'd9, 10);

    mem[0] = 48'h0F0F_0F0F_0F0F; mem[15] = 48'hF0F0_F0F0_F0F0;
    lookup("b2b_0", 48'h0F0F_0F0F_0F0F, 16'hFFFF, 1'b1, 4'd0, 0);
    lookup("b2b_15", 48'hF0F0_F0F0_F0F0, 16'hFFFF, 1'b1, 4'd15, 0);

    @(negedge CLK);
    req_key = 48'hDEAD_BEEF_0000; entry_valid = 16'hFFFF; req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check("scan_raddr_c1", 64'(raddr), 64'd0);
    repeat (7) @(posedge CLK);
    #1;
    check("scan_raddr_c8", 64'(raddr), 64'd7);
    ARST_N = 1'b0;
    #1;
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_rsp_hit", 64'(rsp_hit), 64'd0);
    check("midrst_rsp_index", 64'(rsp_index), 64'd0);
    check("midrst_raddr", 64'(raddr), 64'd0);
    @(negedge CLK); ARST_N = 1'b1;
    @(posedge CLK); #1;
    check("midrst_rel_ready", 64'(req_ready), 64'd1);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge CLK); #1;
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", 64'(seen), 64'd0);

    lookup("after_rst", 48'h0011_2233_4455, 16'hFFFF, 1'b1, 4'd5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
